// File: rtl/shifter_seq.sv
// Iterative operand-2 shifter: LSL/LSR/ASR/ROR one bit per clock with ARM-style carry-out,
// behind a start/done handshake. Feeds the ALU B input and shiftCout.
module shifter_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AMT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       shift_type,
  input  logic [AMT_W-1:0] shift_amt,
  input  logic [WIDTH-1:0] data_in,
  input  logic             c_in,
  output logic [WIDTH-1:0] data_out,
  output logic             shift_cout,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CntW = $clog2(WIDTH + 2);

  localparam logic [1:0] ShLsl = 2'b00;
  localparam logic [1:0] ShLsr = 2'b01;
  localparam logic [1:0] ShAsr = 2'b10;
  localparam logic [1:0] ShRor = 2'b11;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] data_q;
  logic             cout_q;
  logic [1:0]       type_q;
  logic [CntW-1:0]  cnt_q;

  int unsigned      amt_int;
  int unsigned      rot_int;
  logic [CntW-1:0]  n_init;
  logic [WIDTH-1:0] step_data;
  logic             step_cout;

  assign amt_int = 32'(shift_amt);
  assign rot_int = amt_int % WIDTH;

  // Iteration count; large amounts saturate so the 1-bit steps yield ARM results naturally.
  always_comb begin
    n_init = '0;
    unique case (shift_type)
      ShLsl, ShLsr: n_init = (amt_int > WIDTH + 1) ? CntW'(WIDTH + 1) : CntW'(amt_int);
      ShAsr:        n_init = (amt_int > WIDTH) ? CntW'(WIDTH) : CntW'(amt_int);
      ShRor: begin
        if (amt_int == 0) begin
          n_init = '0;
        end else if (rot_int == 0) begin
          n_init = CntW'(WIDTH);
        end else begin
          n_init = CntW'(rot_int);
        end
      end
      default: n_init = '0;
    endcase
  end

  always_comb begin
    step_data = data_q;
    step_cout = cout_q;
    unique case (type_q)
      ShLsl: begin
        step_cout = data_q[WIDTH-1];
        step_data = {data_q[WIDTH-2:0], 1'b0};
      end
      ShLsr: begin
        step_cout = data_q[0];
        step_data = {1'b0, data_q[WIDTH-1:1]};
      end
      ShAsr: begin
        step_cout = data_q[0];
        step_data = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
      end
      ShRor: begin
        step_cout = data_q[0];
        step_data = {data_q[0], data_q[WIDTH-1:1]};
      end
      default: begin
        step_cout = cout_q;
        step_data = data_q;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      data_q  <= '0;
      cout_q  <= 1'b0;
      type_q  <= ShLsl;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            data_q  <= data_in;
            type_q  <= shift_type;
            cout_q  <= c_in;
            cnt_q   <= n_init;
            state_q <= (n_init != '0) ? StShift : StDone;
          end else begin
            state_q <= StIdle;
          end
        end
        StShift: begin
          data_q <= step_data;
          cout_q <= step_cout;
          cnt_q  <= cnt_q - 1'b1;
          if (cnt_q == CntW'(1)) begin
            state_q <= StDone;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign data_out   = data_q;
  assign shift_cout = cout_q;
  assign busy       = (state_q == StShift);
  assign done       = (state_q == StDone);

endmodule

// File: tb/tb_shifter_seq.sv
// Self-checking bench for shifter_seq: directed table, handshake corner cases, and random
// operations checked against an arithmetic reference model.
module tb_shifter_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  shift_type;
  logic [7:0]  shift_amt;
  logic [31:0] data_in;
  logic        c_in;
  logic [31:0] data_out;
  logic        shift_cout;
  logic        busy;
  logic        done;

  int vectors;
  int miscompares;

  shifter_seq #(.WIDTH(32), .AMT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .shift_type (shift_type),
    .shift_amt  (shift_amt),
    .data_in    (data_in),
    .c_in       (c_in),
    .data_out   (data_out),
    .shift_cout (shift_cout),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  t;
    logic [7:0]  a;
    logic [31:0] d;
    logic        c;
    logic [31:0] ed;
    logic        ec;
    int          en;
  } vec_t;

  function automatic void check(input string name, input logic [63:0] got,
                                input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endfunction

  // Reference: ARM shifter semantics by whole-word arithmetic, plus the iteration count.
  function automatic void model(input logic [1:0] t, input logic [7:0] a, input logic [31:0] d,
                                input logic c, output logic [31:0] rd, output logic rc,
                                output int n);
    logic [63:0] w;
    int r;
    rd = d;
    rc = c;
    n  = 0;
    if (a == 0) return;
    case (t)
      2'b00: begin
        w  = {32'h0, d} << a;
        rd = w[31:0];
        rc = w[32];
        n  = (a > 33) ? 33 : int'(a);
      end
      2'b01: begin
        w  = {d, 32'h0} >> a;
        rd = w[63:32];
        rc = w[31];
        n  = (a > 33) ? 33 : int'(a);
      end
      2'b10: begin
        n  = (a > 32) ? 32 : int'(a);
        w  = {d, 32'h0};
        w  = $signed(w) >>> n;
        rd = w[63:32];
        rc = w[31];
      end
      default: begin
        r = int'(a) % 32;
        if (r == 0) begin
          rd = d;
          n  = 32;
        end else begin
          rd = (d >> r) | (d << (32 - r));
          n  = r;
        end
        rc = rd[31];
      end
    endcase
  endfunction

  // Issue one request from IDLE/DONE and wait for done; returns with the DONE cycle sampled.
  task automatic run_op(input logic [1:0] t, input logic [7:0] a, input logic [31:0] d,
                        input logic c, input bit poke, output logic [31:0] od,
                        output logic oc, output int lat, output int bcnt);
    shift_type = t;
    shift_amt  = a;
    data_in    = d;
    c_in       = c;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start      = 1'b0;
    shift_type = 2'($urandom);
    shift_amt  = 8'($urandom);
    data_in    = $urandom;
    c_in       = 1'($urandom);
    lat  = 0;
    bcnt = 0;
    while (!done && lat < 40) begin
      if (busy) bcnt++;
      if (poke) begin
        start      = 1'b1;
        shift_type = 2'($urandom);
        shift_amt  = 8'($urandom);
        data_in    = $urandom;
        c_in       = 1'($urandom);
      end
      @(posedge clk);
      #1;
      lat++;
    end
    start = 1'b0;
    od    = data_out;
    oc    = shift_cout;
  endtask

  task automatic check_op(input string name, input logic [1:0] t, input logic [7:0] a,
                          input logic [31:0] d, input logic c, input bit poke,
                          input logic [31:0] ed, input logic ec, input int en);
    logic [31:0] od;
    logic        oc;
    int          lat;
    int          bcnt;
    run_op(t, a, d, c, poke, od, oc, lat, bcnt);
    check({name, " done"}, 64'(done), 64'(1));
    check({name, " data"}, 64'(od), 64'(ed));
    check({name, " cout"}, 64'(oc), 64'(ec));
    check({name, " latency"}, 64'(lat), 64'(en));
    check({name, " busy cycles"}, 64'(bcnt), 64'(en));
  endtask

  vec_t vecs[$];

  initial begin
    logic [31:0] ed;
    logic        ec;
    int          en;
    int          gap;
    bit          saw_done;
    logic [31:0] held;
    logic [1:0]  rt;
    logic [7:0]  ra;
    logic [31:0] rdat;
    logic        rc;

    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    start       = 1'b0;
    shift_type  = 2'b00;
    shift_amt   = 8'h0;
    data_in     = 32'h0;
    c_in        = 1'b0;

    vecs.push_back('{2'b00, 8'd4,   32'h8000_000F, 1'b0, 32'h0000_00F0, 1'b0, 4});
    vecs.push_back('{2'b01, 8'd32,  32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 32});
    vecs.push_back('{2'b01, 8'd40,  32'h8000_0000, 1'b1, 32'h0000_0000, 1'b0, 33});
    vecs.push_back('{2'b10, 8'd200, 32'h8000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 32});
    vecs.push_back('{2'b10, 8'd1,   32'h7FFF_FFFF, 1'b0, 32'h3FFF_FFFF, 1'b1, 1});
    vecs.push_back('{2'b11, 8'd36,  32'h0000_0010, 1'b1, 32'h0000_0001, 1'b0, 4});
    vecs.push_back('{2'b11, 8'd32,  32'h8000_0001, 1'b0, 32'h8000_0001, 1'b1, 32});
    vecs.push_back('{2'b00, 8'd32,  32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 32});
    vecs.push_back('{2'b00, 8'd33,  32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 1'b0, 33});
    vecs.push_back('{2'b00, 8'd1,   32'h7FFF_FFFF, 1'b1, 32'hFFFF_FFFE, 1'b0, 1});
    vecs.push_back('{2'b00, 8'd0,   32'h1234_5678, 1'b1, 32'h1234_5678, 1'b1, 0});
    vecs.push_back('{2'b01, 8'd0,   32'h1234_5678, 1'b1, 32'h1234_5678, 1'b1, 0});
    vecs.push_back('{2'b10, 8'd0,   32'h1234_5678, 1'b1, 32'h1234_5678, 1'b1, 0});
    vecs.push_back('{2'b11, 8'd0,   32'h1234_5678, 1'b1, 32'h1234_5678, 1'b1, 0});
    vecs.push_back('{2'b11, 8'd0,   32'hA5A5_0000, 1'b0, 32'hA5A5_0000, 1'b0, 0});

    #12;
    check("reset data_out", 64'(data_out), 64'(0));
    check("reset cout", 64'(shift_cout), 64'(0));
    check("reset busy", 64'(busy), 64'(0));
    check("reset done", 64'(done), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("idle busy", 64'(busy), 64'(0));
    check("idle done", 64'(done), 64'(0));

    // Directed table, issued back-to-back: each new start lands in the previous DONE cycle.
    foreach (vecs[i]) begin
      check_op($sformatf("vec%0d", i), vecs[i].t, vecs[i].a, vecs[i].d, vecs[i].c, 1'b0,
               vecs[i].ed, vecs[i].ec, vecs[i].en);
    end

    // done lasts one cycle; outputs hold in IDLE.
    held = data_out;
    rc   = shift_cout;
    @(posedge clk);
    #1;
    check("done pulse width", 64'(done), 64'(0));
    check("idle after done busy", 64'(busy), 64'(0));
    check("idle hold data", 64'(data_out), 64'(held));
    check("idle hold cout", 64'(shift_cout), 64'(rc));

    // start pulses with new operands during SHIFT are ignored.
    check_op("start during shift", 2'b00, 8'd8, 32'h0000_00FF, 1'b0, 1'b1,
             32'h0000_FF00, 1'b0, 8);
    @(posedge clk);
    #1;

    // Reset mid-SHIFT: outputs clear asynchronously and no done follows.
    shift_type = 2'b10;
    shift_amt  = 8'd20;
    data_in    = 32'hDEAD_BEEF;
    c_in       = 1'b1;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("mid-shift rst data", 64'(data_out), 64'(0));
    check("mid-shift rst cout", 64'(shift_cout), 64'(0));
    check("mid-shift rst busy", 64'(busy), 64'(0));
    check("mid-shift rst done", 64'(done), 64'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (done || busy) saw_done = 1'b1;
    end
    check("no activity after rst", 64'(saw_done), 64'(0));

    // Random operations against the reference model, with random idle gaps.
    for (int k = 0; k < 300; k++) begin
      rt = 2'($urandom);
      case ($urandom_range(0, 3))
        0:       ra = 8'($urandom_range(0, 255));
        1:       ra = 8'($urandom_range(30, 34));
        2:       ra = 8'($urandom_range(60, 68));
        default: ra = 8'($urandom_range(0, 8));
      endcase
      rdat = $urandom;
      rc   = 1'($urandom);
      model(rt, ra, rdat, rc, ed, ec, en);
      check_op($sformatf("rnd%0d t%0d a%0d", k, rt, ra), rt, ra, rdat, rc, 1'($urandom), ed, ec,
               en);
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        @(posedge clk);
        #1;
        if (g == 0) begin
          check($sformatf("rnd%0d idle hold", k), 64'({done, data_out}), 64'({1'b0, ed}));
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/shifter_seq.md
# shifter_seq

Iterative operand-2 shifter for the execute stage, directly upstream of the ALU. It shifts or rotates the second operand one bit per clock and returns the shifted value and the shifter carry-out. Its outputs drive the ALU `B` input and `shiftCout` input. It implements ARM-style LSL/LSR/ASR/ROR semantics, including the zero-amount and large-amount cases, behind a start/done handshake.

## Interface
Parameters:
- `WIDTH`, 32, data width; the spec is written for 32.
- `AMT_W`, 8, shift-amount width; amounts 0..255.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `start`  in  1  request; sampled only when idle or in DONE.
- `shift_type`  in  2  shift kind: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
- `shift_amt`  in  AMT_W  requested shift amount.
- `data_in`  in  WIDTH  operand to shift.
- `c_in`  in  1  current C flag; passed through when the amount is 0.
- `data_out`  out  WIDTH  shifted result; drives ALU `B`.
- `shift_cout`  out  1  shifter carry-out; drives ALU `shiftCout`.
- `busy`  out  1  high while in SHIFT.
- `done`  out  1  one-cycle pulse; result valid.

## Operation
States: IDLE, SHIFT, DONE.

Accepting a request (edge E0, with `start`=1 and state IDLE or DONE):
- Latch `data_in` into the working register and `shift_type` into the type register.
- Set `shift_cout` to `c_in`.
- Load the iteration count n from the table below.
- Go to SHIFT if n>0, otherwise go to DONE.

Effective iteration count n (a = `shift_amt`):
- LSL, LSR: n = min(a, 33).
- ASR: n = min(a, 32).
- ROR: n = 0 if a=0; otherwise a mod 32, replaced by 32 when a mod 32 = 0.

Each SHIFT edge performs one 1-bit step and decrements n:
- LSL: C←bit31, data←{data[30:0],0}.
- LSR: C←bit0, data←{0,data[31:1]}.
- ASR: C←bit0, data←{bit31,data[31:1]}.
- ROR: C←bit0, data←{bit0,data[31:1]}.
- When n reaches 0 on the step edge, go to DONE.

Resulting large-amount behaviour, which follows from the iteration rules and needs no special-case logic:
- LSL/LSR by 32 gives result 0, C = the last bit shifted out.
- LSL/LSR by more than 32 gives result 0, C=0.
- ASR by 32 or more gives all sign bits, C=sign.
- ROR by a nonzero multiple of 32 gives unchanged data, C=bit31.

DONE:
- `done`=1 for exactly one cycle; `data_out` and `shift_cout` hold the final result.
- Next edge: accept a new request if `start`=1 (back-to-back allowed), otherwise go to IDLE.

Outputs and handshake rules:
- `data_out` and `shift_cout` hold their values in IDLE until the next accepted request.
- During SHIFT they show intermediate values; consumers sample only while `done`=1.
- `start` during SHIFT is ignored; no queueing.
- Inputs are sampled only on the accept edge; later changes have no effect.

## Timing
- Reset (async): state IDLE, `data_out`=0, `shift_cout`=0, `busy`=0, `done`=0.
- Reset mid-SHIFT aborts the operation; no `done` is produced.
- `busy` and `done` decode directly from the state register (registered; no comb path from `start`).
- Zero-amount latency: with a=0, `done` is high in the cycle after E0.
- Nonzero latency: `busy` is high from E0 to En; `done` is high between edges En and En+1.
- Worst-case latency: 34 cycles from accept to `done` (LSL/LSR, a ≥ 33).
- Throughput: one operation per n+1 cycles, since accept from DONE is allowed.

## Test plan
- LSL, a=4, `data_in`=0x8000_000F → `data_out`=0x0000_00F0, C=0; `busy` for 4 cycles, `done` in the cycle after E4.
- LSR, a=32, 0x8000_0000 → 0x0000_0000, C=1. Repeat with a=40 → 0x0000_0000, C=0; `done` after 33 shifts.
- ASR, a=200, 0x8000_0001 → 0xFFFF_FFFF, C=1, n=32. Repeat with 0x7FFF_FFFF, a=1 → 0x3FFF_FFFF, C=1.
- ROR, a=36, 0x0000_0010 → 0x0000_0001, C=0, n=4. ROR, a=32, 0x8000_0001 → 0x8000_0001, C=1.
- a=0, any type, `c_in`=1, 0x1234_5678 → unchanged, C=1, `done` the cycle after E0. Then issue back-to-back `start` in the DONE cycle and confirm it is accepted.
- Assert `start` with new operands during SHIFT → ignored, and the original result completes. Assert `rst` mid-SHIFT → all outputs 0 immediately and no `done` pulse.
